// File: rtl/ntt_bf_post.sv
// ntt_bf_post: post-multiply half of the NTT butterfly, emits (a+p) mod Q and (a-p) mod Q plus a stage pair counter.
// Latency: LAT+1 cycles from in_valid to out_valid, one pair per cycle.
// Backpressure: none; the pipeline advances every cycle and bubbles emerge as out_valid=0.
// Optional: define BF_HALF_EN to add in_half, which halves both results mod Q (inverse-NTT scaling).
module ntt_bf_post #(
    parameter int DW    = 13,
    parameter int Q     = 3329,
    parameter int LAT   = 3,
    parameter int PAIRS = 128
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [DW-1:0]            in_a,
`ifdef BF_HALF_EN
    input  logic                     in_half,
`endif
    input  logic [DW-1:0]            mul_out,
    output logic                     out_valid,
    output logic [DW-1:0]            out_even,
    output logic [DW-1:0]            out_odd,
    output logic                     out_last,
    output logic [$clog2(PAIRS)-1:0] pair_cnt
);

    localparam int              CW   = $clog2(PAIRS);
    localparam logic [DW:0]     QW   = (DW+1)'(Q);
    localparam logic [CW-1:0]   LAST = CW'(PAIRS - 1);

    // Delay line matching the multiplier latency; the last stage lines up with mul_out.
    logic [LAT-1:0] vld_q;
    logic [DW-1:0]  a_q [LAT];
`ifdef BF_HALF_EN
    logic [LAT-1:0] half_q;
`endif

    logic [DW-1:0]  out_even_q, out_odd_q;
    logic           out_valid_q;
    logic [CW-1:0]  cnt_q, cnt_d;

    logic [DW:0]    m_ext, p_red, sum_w, dif_w;
    logic [DW-1:0]  even_d, odd_d;

`ifdef BF_HALF_EN
    // x/2 mod Q: odd values borrow one Q first so the shift is exact; x+Q < 2^(DW+1).
    function automatic logic [DW-1:0] half_mod(input logic [DW-1:0] x);
        logic [DW:0] t;
        t = {1'b0, x} + (x[0] ? QW : '0);
        return DW'(t >> 1);
    endfunction
`endif

    // Valid bits of the delay line are reset so in-flight pairs are dropped.
    always_ff @(posedge clk) begin
        if (!rst) begin
            vld_q <= '0;
        end else begin
            vld_q[0] <= in_valid;
            for (int i = 1; i < LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
            end
        end
    end

    // Operand (and half flag) delay line; contents are meaningless without the valid bit.
    always_ff @(posedge clk) begin
        a_q[0] <= in_a;
        for (int i = 1; i < LAT; i++) begin
            a_q[i] <= a_q[i-1];
        end
`ifdef BF_HALF_EN
        half_q[0] <= in_half;
        for (int i = 1; i < LAT; i++) begin
            half_q[i] <= half_q[i-1];
        end
`endif
    end

    // Reduce the product once, then form the modular sum and difference.
    always_comb begin
        m_ext  = {1'b0, mul_out};
        p_red  = (m_ext >= QW) ? m_ext - QW : m_ext;
        sum_w  = {1'b0, a_q[LAT-1]} + p_red;
        dif_w  = {1'b0, a_q[LAT-1]} - p_red;
        even_d = DW'((sum_w >= QW) ? sum_w - QW : sum_w);
        odd_d  = DW'(dif_w[DW] ? dif_w + QW : dif_w);
`ifdef BF_HALF_EN
        if (half_q[LAT-1]) begin
            even_d = half_mod(even_d);
            odd_d  = half_mod(odd_d);
        end
`endif
    end

    // Output register; data only moves on valid pairs so it holds across bubbles.
    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            out_even_q  <= '0;
            out_odd_q   <= '0;
        end else begin
            out_valid_q <= vld_q[LAT-1];
            if (vld_q[LAT-1]) begin
                out_even_q <= even_d;
                out_odd_q  <= odd_d;
            end
        end
    end

    // Pair index steps after each emitted pair and wraps after the last pair of a stage.
    always_comb begin
        cnt_d = cnt_q;
        if (out_valid_q) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    // Pair counter state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_even  = out_even_q;
    assign out_odd   = out_odd_q;
    assign pair_cnt  = cnt_q;
    assign out_last  = out_valid_q && (cnt_q == LAST);

endmodule

// File: tb/tb_ntt_bf_post.sv
// Directed bench for ntt_bf_post: hand vectors, a long stream with bubbles, and a mid-stream reset.
// Each call of cyc() drives one cycle; mul_out is fed LAT calls after its operand, like a real multiplier.
// The output sampled in call n belongs to the operand driven in call n-LAT.
module tb_ntt_bf_post;
    localparam int DW    = 13;
    localparam int Q     = 3329;
    localparam int LAT   = 3;
    localparam int PAIRS = 128;
    localparam int CW    = $clog2(PAIRS);
    localparam int NMAX  = 2048;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_a = '0;
    logic [DW-1:0] mul_out = '0;
`ifdef BF_HALF_EN
    logic          in_half = 1'b0;
`endif
    logic          out_valid;
    logic [DW-1:0] out_even;
    logic [DW-1:0] out_odd;
    logic          out_last;
    logic [CW-1:0] pair_cnt;

    always #5 clk = ~clk;

    ntt_bf_post #(.DW(DW), .Q(Q), .LAT(LAT), .PAIRS(PAIRS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_a      (in_a),
`ifdef BF_HALF_EN
        .in_half   (in_half),
`endif
        .mul_out   (mul_out),
        .out_valid (out_valid),
        .out_even  (out_even),
        .out_odd   (out_odd),
        .out_last  (out_last),
        .pair_cnt  (pair_cnt)
    );

    int checks = 0;
    int errors = 0;

    int n = 0;
    int e_v [NMAX];
    int e_a [NMAX];
    int e_m [NMAX];
    int e_h [NMAX];
    int ob_e [NMAX];
    int ob_o [NMAX];
    int exp_cnt = 0;
    int last_e = 0;
    int last_o = 0;
    int last_seen = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Reference arithmetic written with plain integer modulo, independent of the RTL structure.
    function automatic int ref_even(input int a, input int m, input int h);
        int r;
        r = (a + (m % Q)) % Q;
        if (h != 0) r = (r * 1665) % Q;
        return r;
    endfunction

    function automatic int ref_odd(input int a, input int m, input int h);
        int r;
        r = (a - (m % Q) + Q) % Q;
        if (h != 0) r = (r * 1665) % Q;
        return r;
    endfunction

    task automatic cyc(input bit r, input bit v, input int a, input int m, input bit h);
        int k;
        int al;
        int xe;
        int xo;
        k  = n;
        al = n - LAT;
        e_v[k] = v;
        e_a[k] = a;
        e_m[k] = m;
        e_h[k] = h;
        rst      = r;
        in_valid = v;
        in_a     = DW'(a);
`ifdef BF_HALF_EN
        in_half  = h;
`endif
        if (al >= 0 && e_v[al] != 0) mul_out = DW'(e_m[al]);
        else                         mul_out = DW'(6000);
        @(posedge clk);
        #1;
        if (out_last) last_seen++;
        if (!r) begin
            for (int j = al; j <= k; j++) if (j >= 0) e_v[j] = 0;
            exp_cnt = 0;
            last_e  = 0;
            last_o  = 0;
            chk("rst_valid", 32'(out_valid), 0);
            chk("rst_even",  32'(out_even),  0);
            chk("rst_odd",   32'(out_odd),   0);
            chk("rst_cnt",   32'(pair_cnt),  0);
            chk("rst_last",  32'(out_last),  0);
        end else if (al >= 0 && e_v[al] != 0) begin
            xe = ref_even(e_a[al], e_m[al], e_h[al]);
            xo = ref_odd(e_a[al], e_m[al], e_h[al]);
            chk("pair_valid", 32'(out_valid), 1);
            chk("pair_even",  32'(out_even),  xe);
            chk("pair_odd",   32'(out_odd),   xo);
            chk("pair_cnt",   32'(pair_cnt),  exp_cnt);
            chk("pair_last",  32'(out_last),  (exp_cnt == PAIRS - 1) ? 1 : 0);
            ob_e[al] = int'(out_even);
            ob_o[al] = int'(out_odd);
            last_e   = xe;
            last_o   = xo;
            exp_cnt  = (exp_cnt + 1) % PAIRS;
        end else begin
            chk("idle_valid", 32'(out_valid), 0);
            chk("idle_last",  32'(out_last),  0);
            chk("hold_even",  32'(out_even),  last_e);
            chk("hold_odd",   32'(out_odd),   last_o);
        end
        n++;
    endtask

    int i_basic, i_wrap, i_unred, i_zero;
`ifdef BF_HALF_EN
    int i_h1, i_h2;
`endif

    initial begin
        for (int j = 0; j < NMAX; j++) begin
            e_v[j] = 0; e_a[j] = 0; e_m[j] = 0; e_h[j] = 0; ob_e[j] = -1; ob_o[j] = -1;
        end

        // Reset state.
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);

        // Hand-computed vectors.
        i_basic = n; cyc(1, 1, 100, 200, 0);
        i_wrap  = n; cyc(1, 1, 3000, 500, 0);
        i_unred = n; cyc(1, 1, 10, 3334, 0);
        i_zero  = n; cyc(1, 1, 0, 3329, 0);
`ifdef BF_HALF_EN
        i_h1 = n; cyc(1, 1, 1, 0, 1);
        i_h2 = n; cyc(1, 1, 4, 2, 1);
`endif
        repeat (LAT + 2) cyc(1, 0, 0, 0, 0);

        chk("basic_even", ob_e[i_basic], 300);
        chk("basic_odd",  ob_o[i_basic], 3229);
        chk("wrap_even",  ob_e[i_wrap],  171);
        chk("wrap_odd",   ob_o[i_wrap],  2500);
        chk("unred_even", ob_e[i_unred], 15);
        chk("unred_odd",  ob_o[i_unred], 5);
        chk("zero_even",  ob_e[i_zero],  0);
        chk("zero_odd",   ob_o[i_zero],  0);
`ifdef BF_HALF_EN
        chk("half1_even", ob_e[i_h1], 1665);
        chk("half1_odd",  ob_o[i_h1], 1665);
        chk("half2_even", ob_e[i_h2], 3);
        chk("half2_odd",  ob_o[i_h2], 1);
`endif

        // Restart the stage count, then a 300-pair stream followed by a 3-cycle bubble.
        cyc(0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        last_seen = 0;
        for (int i = 0; i < 300; i++) begin
            cyc(1, 1, int'($urandom_range(Q - 1, 0)), int'($urandom_range(2 * Q - 1, 0)), 0);
        end
        repeat (3) cyc(1, 0, 0, 0, 0);

        // 50 more valids fill the pipeline, then a one-cycle reset mid-stream.
        for (int i = 0; i < 50; i++) begin
            cyc(1, 1, int'($urandom_range(Q - 1, 0)), int'($urandom_range(2 * Q - 1, 0)), 0);
        end
        chk("stream_last_count", last_seen, 2);
        cyc(0, 0, 0, 0, 0);

        last_seen = 0;
        for (int i = 0; i < 140; i++) begin
            cyc(1, 1, int'($urandom_range(Q - 1, 0)), int'($urandom_range(2 * Q - 1, 0)), 0);
        end
        repeat (LAT + 2) cyc(1, 0, 0, 0, 0);
        chk("post_rst_last_count", last_seen, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ntt_bf_post.md
Name: ntt_bf_post

Overview:
- Post-multiply half of the NTT Cooley-Tukey butterfly, directly downstream of mo_mul.
- Receives the top operand a on the same cycle the multiplier receives its operands.
- Delays a and its valid by the multiplier latency so they line up with the product p = mo_mul.result.
- Produces the registered pair (a+p) mod Q and (a−p) mod Q, with a pair counter that flags the last pair of each NTT stage.

Parameters:
- DW, `DATA_WIDTH, coefficient width.
- Q, `Q, modulus; 3329 in all examples below.
- LAT, `MUL_STAGE_CNT, mo_mul latency in cycles (a registered mo_mul has LAT>=1).
- PAIRS, 128, butterflies per stage; out_last period.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low
- in_valid  in  1  operands presented to mo_mul and to this block this cycle
- in_a  in  DW  top butterfly operand, range [0,Q)
- mul_out  in  DW  mo_mul.result; range [0,2Q)
- out_valid  out  1  output pair valid
- out_even  out  DW  (a+p) mod Q
- out_odd  out  DW  (a−p) mod Q
- out_last  out  1  asserted with the PAIRS-th valid pair of each stage
- pair_cnt  out  clog2(PAIRS)  index of the current output pair

Behaviour:
- Reset (rst==0 at a clk edge):
  - out_valid, out_last, out_even, out_odd and pair_cnt go to 0.
  - All delay-line valid bits go to 0; delay-line data is don't-care.
- Alignment:
  - LAT-deep shift register carries {in_valid, in_a} (stage 0 = inputs, advancing every cycle).
  - The stage-LAT entry is paired with mul_out in that same cycle.
- No back-pressure:
  - The pipeline advances every cycle.
  - in_valid may be asserted back-to-back indefinitely.
  - Bubbles propagate as out_valid=0.
- Arithmetic, combinational then one output register:
  - p' = (mul_out>=Q) ? mul_out−Q : mul_out.
  - s = a+p' (DW+1 bits); even = (s>=Q) ? s−Q : s.
  - d = a−p' (signed DW+1); odd = (d<0) ? d+Q : d.
  - Outputs are always in [0,Q).
- Latency: out_valid for a given in_valid appears exactly LAT+1 cycles later; a throughput of 1 pair/cycle is required.
- Data outputs hold their last value while out_valid=0; out_even/out_odd only update on valid cycles.
- Pair counter:
  - pair_cnt shows the index of the pair on the outputs and advances after each valid pair.
  - out_last=1 iff out_valid and pair_cnt==PAIRS−1.
  - On that pair the counter wraps to 0.
- Invalid delay-line entries never increment the counter, regardless of mul_out value.
- Reset mid-stream:
  - In-flight pairs are discarded and the counter restarts at 0.
  - The first in_valid after rst release yields its output LAT+1 cycles later.
- Simultaneous out_last and a new valid entering the pipeline: no interaction; the counter only depends on the output-stage valid.

Optional Feature:
- Macro BF_HALF_EN adds input port in_half (1 bit).
  - in_half is delayed alongside in_a.
  - When the aligned in_half=1, both results are divided by 2 mod Q before the output register: x/2 = x even ? x>>1 : (x+Q)>>1, computed in DW+1 bits.
  - This is used for the Gentleman-Sande inverse NTT scaling.
  - Latency is unchanged.
- Without BF_HALF_EN: the port is absent and no halving logic is present.

Test Plan:
- Basic case: Q=3329, a=100, mul_out=200 -> LAT+1 cycles later out_valid=1, out_even=300, out_odd=3229.
- Wrap case: a=3000, mul_out=500 -> out_even=171, out_odd=2500.
- Unreduced product: a=10, mul_out=3334 (p'=5) -> out_even=15, out_odd=5; also a=0, mul_out=3329 -> 0, 0.
- Streaming and bubbles:
  - Stimulus: 300 back-to-back valids with PAIRS=128, random a in [0,Q) and mul_out in [0,2Q), then a 3-cycle bubble.
  - Required: every output matches the golden model; out_last on valid pairs 128 and 256; out_valid=0 for exactly 3 cycles.
- Reset mid-stream:
  - Stimulus: assert rst low for 1 cycle after 50 valids while the pipeline is full.
  - Required: no out_valid for the LAT+1 cycles after release; the next out_last comes on the 128th new pair.
- BF_HALF_EN: a=1, mul_out=0, in_half=1 -> out_even=1665, out_odd=1665; a=4, mul_out=2, in_half=1 -> out_even=3, out_odd=1.
